// File: rtl/npu_pkg.sv
// Shared NPU definitions: BF16 field constants, NaN test and the result-drain state encoding.
package npu_pkg;

  localparam int BF16_W = 16;
  localparam logic [BF16_W-1:0] BF16_EXP_MASK = 16'h7F80;
  localparam logic [BF16_W-1:0] BF16_MAN_MASK = 16'h007F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STREAM
  } drain_state_t;

  // NaN needs an all-ones exponent and a nonzero mantissa; +/-Inf has a zero mantissa.
  function automatic logic bf16_is_nan(input logic [BF16_W-1:0] v);
    return ((v & BF16_EXP_MASK) == BF16_EXP_MASK) && ((v & BF16_MAN_MASK) != '0);
  endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// Valid/ready result stream from mac_result_drain toward the writeback path.
interface mac_result_drain_if #(
  parameter int ARRAY_SIZE = 32,
  parameter int DATA_W     = 16,
  parameter int LANES      = 4
);
  localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_data;
  logic [IDX_W-1:0]          out_index;
  logic                      out_last;

  modport master (output out_valid, out_data, out_index, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);

endinterface

// File: rtl/mac_result_drain.sv
// Waits a programmed latency after start, snapshots the MAC array results and
// streams them out LANES elements per beat, flagging any BF16 NaN in the snapshot.
module mac_result_drain
  import npu_pkg::*;
#(
  parameter int ARRAY_SIZE = 32,
  parameter int DATA_W     = 16,
  parameter int LANES      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CNT_W-1:0]             wait_cycles,
  input  logic [ARRAY_SIZE*DATA_W-1:0] c_matrix,
  mac_result_drain_if.master           out_if,
  output logic                         busy,
  output logic                         done,
  output logic                         nan_flag
);

  localparam int NUM_BEATS = ARRAY_SIZE / LANES;
  localparam int IDX_W     = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  generate
    if (ARRAY_SIZE % LANES != 0) begin : g_bad_lanes
      $error("mac_result_drain: ARRAY_SIZE must be a multiple of LANES");
    end
    if (DATA_W != BF16_W) begin : g_bad_width
      $error("mac_result_drain: DATA_W must equal BF16_W");
    end
  endgenerate

  drain_state_t      r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BEAT_W-1:0] r_beat;
  logic [DATA_W-1:0] r_buf [ARRAY_SIZE];
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_done;
  logic              r_nan;

  logic              w_any_nan;
  logic              w_accept;
  logic [IDX_W-1:0]  w_base;

  always_comb begin
    // NOTE: default before the loop so every path assigns it and no latch is inferred.
    w_any_nan = 1'b0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      w_any_nan = w_any_nan | bf16_is_nan(c_matrix[i*DATA_W +: DATA_W]);
    end
  end

  assign w_accept = r_valid & out_if.out_ready;
  assign w_base   = IDX_W'(int'(r_beat) * LANES);

  // Lane mux reads only registered state, so out_data never depends on out_ready.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign out_if.out_data[g*DATA_W +: DATA_W] = r_buf[w_base + IDX_W'(g)];
  end

  // NOTE: sequential state uses <= only, so every branch sees the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_nan   <= 1'b0;
      // NOTE: the buffer is reset because out_data is read straight from it and must be 0 out of reset.
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt   <= wait_cycles;
            r_nan   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            for (int i = 0; i < ARRAY_SIZE; i++) begin
              r_buf[i] <= c_matrix[i*DATA_W +: DATA_W];
            end
            r_nan   <= w_any_nan;
            r_beat  <= '0;
            r_valid <= 1'b1;
            r_last  <= (NUM_BEATS == 1);
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_accept) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_beat  <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
              r_last <= ((r_beat + 1'b1) == LAST_BEAT);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_if.out_valid = r_valid;
  assign out_if.out_last  = r_last;
  assign out_if.out_index = w_base;
  assign busy             = r_busy;
  assign done             = r_done;
  assign nan_flag         = r_nan;

endmodule

// File: tb/tb_mac_result_drain.sv
// Table-driven bench for mac_result_drain: each job's expected beats go to a
// scoreboard queue at start and are compared as the DUT streams them out.
module tb_mac_result_drain;

  localparam int ARRAY_SIZE = 32;
  localparam int DATA_W     = 16;
  localparam int LANES      = 4;
  localparam int CNT_W      = 16;
  localparam int NUM_BEATS  = ARRAY_SIZE / LANES;
  localparam int MW         = ARRAY_SIZE * DATA_W;
  localparam int BW         = LANES * DATA_W;

  typedef enum logic {FILL_CONST, FILL_RAMP} fill_t;

  typedef struct {
    logic [CNT_W-1:0] wait_cyc;
    fill_t            fill;
    logic [15:0]      fill_val;
    int               nan_idx;
    logic [15:0]      nan_val;
    bit               ready_pat;
    bit               zero_after;
    bit               second_start;
    logic             exp_nan;
    logic [BW-1:0]    exp_b3;
  } job_t;

  typedef struct {
    logic [4:0]    idx;
    logic [BW-1:0] data;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] wait_cycles = '0;
  logic [MW-1:0]    c_matrix = '0;
  logic             busy;
  logic             done;
  logic             nan_flag;

  int    checks = 0;
  int    failures = 0;
  beat_t sb[$];
  job_t  jobs[8];

  mac_result_drain_if #(.ARRAY_SIZE(ARRAY_SIZE), .DATA_W(DATA_W), .LANES(LANES)) dif ();

  mac_result_drain #(
    .ARRAY_SIZE(ARRAY_SIZE), .DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wait_cycles(wait_cycles),
    .c_matrix(c_matrix), .out_if(dif), .busy(busy), .done(done), .nan_flag(nan_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] build(input job_t j);
    logic [MW-1:0] m;
    logic [15:0]   e;
    m = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      e = (j.fill == FILL_RAMP) ? j.fill_val + 16'(i) : j.fill_val;
      if (i == j.nan_idx) e = j.nan_val;
      m[i*DATA_W +: DATA_W] = e;
    end
    return m;
  endfunction

  function automatic logic ready_of(input bit pat, input int n);
    if (!pat) return 1'b1;
    return ((n % 4) == 0) || ((n % 4) == 3);
  endfunction

  task automatic run_job(input job_t j);
    logic [MW-1:0] mat;
    beat_t bt;
    int    beats = 0;
    bit    pend_done = 0, finished = 0, seen = 0, bad_done = 0, bad_drop = 0, idle_bad = 0;
    logic  rdy;
    mat = build(j);
    for (int b = 0; b < NUM_BEATS; b++) begin
      bt.idx  = 5'(b * LANES);
      bt.data = mat[b*BW +: BW];
      bt.last = (b == NUM_BEATS - 1);
      sb.push_back(bt);
    end
    @(negedge clk);
    start = 1'b1;
    wait_cycles = j.wait_cyc;
    c_matrix = mat;
    for (int n = 1; n <= 200 && !finished; n++) begin
      @(negedge clk);
      start = j.second_start && (n == 1 || n == 3);
      if (n == 1) check("busy_rise", busy, 1'b1);
      if (pend_done) begin
        check("done_pulse_busy_valid", {done, busy, dif.out_valid}, 3'b100);
        check("nan_hold", nan_flag, j.exp_nan);
        finished = 1;
      end else begin
        if (done) bad_done = 1;
        rdy = ready_of(j.ready_pat, n);
        if (dif.out_valid) begin
          if (!seen) begin
            seen = 1;
            check("first_valid_cycle", n, j.wait_cyc + 2);
            check("nan_at_capture", nan_flag, j.exp_nan);
            if (j.zero_after) c_matrix = '0;
          end
          if (sb.size() == 0) begin
            check("extra_beat", dif.out_valid, 1'b0);
          end else begin
            check("beat", {dif.out_index, dif.out_data, dif.out_last},
                  {sb[0].idx, sb[0].data, sb[0].last});
          end
          if (dif.out_index == 5'd12) check("beat3_data", dif.out_data, j.exp_b3);
          dif.out_ready = rdy;
          if (rdy && sb.size() != 0) begin
            bt = sb.pop_front();
            beats++;
            if (bt.last) pend_done = 1;
          end
        end else begin
          if (seen) bad_drop = 1;
          dif.out_ready = rdy;
        end
      end
    end
    start = 1'b0;
    dif.out_ready = 1'b0;
    if (!finished) check("job_timeout", 1'b0, 1'b1);
    check("beat_count", beats, NUM_BEATS);
    check("queue_empty", sb.size(), 0);
    check("stray_done_or_valid_drop", {bad_done, bad_drop}, 2'b00);
    repeat (3) begin
      @(negedge clk);
      if (dif.out_valid || done || busy) idle_bad = 1;
    end
    check("idle_after_job", idle_bad, 1'b0);
    sb.delete();
  endtask

  task automatic reset_mid_stream();
    job_t j;
    bit   hit = 0, bad_done = 0;
    j = jobs[3];
    @(negedge clk);
    start = 1'b1;
    wait_cycles = j.wait_cyc;
    c_matrix = build(j);
    dif.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      if (dif.out_valid && dif.out_index == 5'd12) hit = 1;
      else @(negedge clk);
    end
    check("reached_beat3", hit, 1'b1);
    check("nan_before_reset", nan_flag, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_flags", {dif.out_valid, dif.out_last, busy, done, nan_flag}, 5'b0);
    check("async_reset_index_data", {dif.out_index, dif.out_data}, '0);
    repeat (2) begin
      @(negedge clk);
      if (done) bad_done = 1;
    end
    rst_n = 1'b1;
    dif.out_ready = 1'b0;
    @(negedge clk);
    if (done) bad_done = 1;
    check("no_done_after_abort", bad_done, 1'b0);
    check("idle_after_abort", {dif.out_valid, busy, nan_flag}, 3'b0);
  endtask

  initial begin
    jobs[0] = '{16'd5, FILL_CONST, 16'h3F80, -1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0,
                64'h3F80_3F80_3F80_3F80};
    jobs[1] = '{16'd3, FILL_RAMP,  16'h0000, -1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0,
                64'h000F_000E_000D_000C};
    jobs[2] = '{16'd2, FILL_RAMP,  16'h0100, -1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0,
                64'h010F_010E_010D_010C};
    jobs[3] = '{16'd4, FILL_CONST, 16'h3F80,  5, 16'h7FC1, 1'b0, 1'b0, 1'b0, 1'b1,
                64'h3F80_3F80_3F80_3F80};
    jobs[4] = '{16'd1, FILL_CONST, 16'h7F80, -1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0,
                64'h7F80_7F80_7F80_7F80};
    jobs[5] = '{16'd0, FILL_RAMP,  16'h0200, -1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0,
                64'h020F_020E_020D_020C};
    jobs[6] = '{16'd7, FILL_CONST, 16'hFF80, 31, 16'hFFC0, 1'b1, 1'b0, 1'b0, 1'b1,
                64'hFF80_FF80_FF80_FF80};
    jobs[7] = '{16'd2, FILL_CONST, 16'h3F80, 12, 16'h7F7F, 1'b0, 1'b0, 1'b0, 1'b0,
                64'h3F80_3F80_3F80_7F7F};

    dif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_flags", {dif.out_valid, dif.out_last, busy, done, nan_flag}, 5'b0);
    check("reset_index_data", {dif.out_index, dif.out_data}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {dif.out_valid, busy, done}, 3'b0);

    for (int i = 0; i < 8; i++) run_job(jobs[i]);
    reset_mid_stream();
    run_job(jobs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
